axi_txn_scheduler: RTL
======================

// Module: axi_txn_scheduler
// PURPOSE
//  Grants one AXI address channel at a time among M0 read (AR), M1 read (AR) and M1 write (AW).
//  Holds the grant until the whole transaction completes: read last beat, or write response.
//  Sits in the AXI interconnect between the master address ports and the decoder/slave mux.
//  Grant steering is round-robin; write has first priority out of reset.
// PARAMETERS
//  TIMEOUT_CYCLES  256  DATA-phase cycles before forced release (used only with AXI_SCHED_TIMEOUT_EN)
//  CNT_W  $clog2(TIMEOUT_CYCLES+1)  timeout counter width (derived, not overridden)
// PORTS
//  clk          in   1  single clock, all logic posedge
//  rst          in   1  synchronous, active-high reset
//  arvalid_m0   in   1  M0 read address request
//  arvalid_m1   in   1  M1 read address request
//  awvalid_m1   in   1  M1 write address request
//  arready_s    in   1  selected slave AR ready
//  awready_s    in   1  selected slave AW ready
//  rvalid_s     in   1  selected slave R valid
//  rready_m     in   1  granted master R ready
//  rlast_s      in   1  selected slave R last
//  bvalid_s     in   1  selected slave B valid
//  bready_m     in   1  granted master B ready
//  gnt          out  3  one-hot grant {awm1, arm1, arm0}; steers the address/data muxes
//  gnt_write    out  1  1 when gnt[2] is set
//  busy         out  1  state != IDLE
//  timeout_err  out  1  one-cycle pulse on forced release (tied 0 without the macro)
// BEHAVIOUR
//  Reset values:
//   - state=IDLE; gnt=3'b000; gnt_write=0; busy=0; timeout_err=0.
//   - last_gnt=ARM1, so the first priority order is AWM1 > ARM0 > ARM1.
//  All outputs are registered.
//  IDLE:
//   - Any request -> ADDR next cycle, gnt = winner (1-cycle grant latency).
//   - Winner is the first requester after last_gnt in order ARM0 -> ARM1 -> AWM1 -> ARM0.
//   - last_gnt updates on grant.
//  ADDR:
//   - Grant is held until the handshake: gnt[0]|gnt[1] needs ARVALID of the grantee & arready_s;
//     gnt[2] needs awvalid_m1 & awready_s. Then -> DATA.
//   - A requester dropping valid does not abort the grant (AXI forbids the drop).
//  DATA:
//   - Read completes on rvalid_s & rready_m & rlast_s.
//   - Write completes on bvalid_s & bready_m.
//   - Completion -> IDLE; gnt=0 the next cycle. One bubble cycle is mandatory.
//  Simultaneous events:
//   - A request arriving in the completion cycle is arbitrated in the following IDLE cycle.
//   - Requests seen during ADDR/DATA are ignored; no queueing.
//  Reset mid-transaction: return to IDLE and clear gnt in the same edge. No completion is emitted.
//  Non-last R beats keep the grant; ready/valid that do not match the grant are ignored.
// CONFIGURATION
//  AXI_SCHED_TIMEOUT_EN defined:
//   - CNT_W counter clears on ADDR->DATA and increments each DATA cycle without completion.
//   - At TIMEOUT_CYCLES: force IDLE, gnt=0, timeout_err=1 for one cycle.
//   - Completion on the same cycle wins; no error is raised.
//  Undefined: no counter; timeout_err driven constant 0; DATA waits indefinitely.
// STRUCTURE
//  Shared package axi_sched_pkg:
//   - enum sched_state_e {IDLE, ADDR, DATA}
//   - one-hot constants GNT_ARM0=3'b001, GNT_ARM1=3'b010, GNT_AWM1=3'b100
//  Sub-module rr_pick3: combinational round-robin picker (req[2:0], last_gnt[2:0] -> gnt[2:0]).
//  Sequential logic stays in axi_txn_scheduler.
// TESTING
//  1. Reset with all three requests high -> cycle 1: gnt=100.
//     Then AW handshake, B handshake -> gnt=000 for one cycle -> next gnt=001.
//  2. arvalid_m1 only, 4-beat read, rlast on beat 4 -> gnt=010 through 4 beats; release after beat 4.
//  3. All requests held high across 6 transactions -> grants 100,001,010,100,001,010.
//  4. R beat with rlast_s=1 but rready_m=0 -> grant held. rready_m=1 next cycle -> release.
//  5. Assert rst while in DATA -> next edge: gnt=000, busy=0; re-arbitration starts AWM1-first.
//  6. [AXI_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=8] Grant ARM0 with no R beats -> timeout_err pulses
//     after 8 DATA cycles; gnt=000.
//     Repeat with rlast handshake on cycle 8 -> no error.

Source files
------------

// File: rtl/axi_sched_pkg.sv
// axi_sched_pkg: FSM states and one-hot grant encodings shared by the AXI transaction scheduler
package axi_sched_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, DATA} sched_state_e;
  localparam logic [2:0] GNT_ARM0 = 3'b001;
  localparam logic [2:0] GNT_ARM1 = 3'b010;
  localparam logic [2:0] GNT_AWM1 = 3'b100;
endpackage

// File: rtl/rr_pick3.sv
// rr_pick3: combinational 3-way round-robin picker; ports req/last_gnt in, one-hot gnt out
module rr_pick3
  import axi_sched_pkg::*;
(
  input  logic [2:0] req,
  input  logic [2:0] last_gnt,
  output logic [2:0] gnt
);
  logic [1:0] s;
  logic [2:0] rot, p;
  // rotate so the requester right after last_gnt sits at bit 0, pick lowest, rotate back
  always_comb begin
    s = last_gnt == GNT_ARM0 ? 2'd1 : last_gnt == GNT_ARM1 ? 2'd2 : 2'd0;
    rot = s == 2'd1 ? {req[0], req[2:1]} : s == 2'd2 ? {req[1:0], req[2]} : req;
    p = rot[0] ? 3'b001 : rot[1] ? 3'b010 : rot[2] ? 3'b100 : 3'b000;
    gnt = s == 2'd1 ? {p[1:0], p[2]} : s == 2'd2 ? {p[0], p[2:1]} : p;
  end
endmodule

// File: rtl/axi_txn_scheduler.sv
// axi_txn_scheduler: grants one of M0 AR / M1 AR / M1 AW and holds it until the transaction completes.
// Ports: clk, rst (sync, active-high); request valids arvalid_m0/arvalid_m1/awvalid_m1;
// slave/master handshakes arready_s, awready_s, rvalid_s, rready_m, rlast_s, bvalid_s, bready_m;
// outputs gnt {awm1,arm1,arm0}, gnt_write, busy, timeout_err.
// Optional AXI_SCHED_TIMEOUT_EN: force release after TIMEOUT_CYCLES stalled DATA cycles.
module axi_txn_scheduler
  import axi_sched_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arvalid_m0,
  input  logic       arvalid_m1,
  input  logic       awvalid_m1,
  input  logic       arready_s,
  input  logic       awready_s,
  input  logic       rvalid_s,
  input  logic       rready_m,
  input  logic       rlast_s,
  input  logic       bvalid_s,
  input  logic       bready_m,
  output logic [2:0] gnt,
  output logic       gnt_write,
  output logic       busy,
  output logic       timeout_err
);
  sched_state_e state_q, state_d;
  logic [2:0] req, pick, gnt_d, last_q, last_d;
  logic addr_hs, done, tmo;
  assign req = {awvalid_m1, arvalid_m1, arvalid_m0};
  rr_pick3 u_pick (.req(req), .last_gnt(last_q), .gnt(pick));
  // only the grantee's own valid/ready pair counts
  assign addr_hs = ((gnt[0] & arvalid_m0) | (gnt[1] & arvalid_m1)) & arready_s
                 | gnt[2] & awvalid_m1 & awready_s;
  assign done = gnt[2] ? bvalid_s & bready_m : rvalid_s & rready_m & rlast_s;
  assign gnt_write = gnt[2];
  assign busy = state_q != IDLE;
`ifdef AXI_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic terr_q;
  // completion in the final cycle takes precedence over the forced release
  assign tmo = state_q == DATA && !done && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
  assign timeout_err = terr_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      terr_q <= 1'b0;
    end else begin
      cnt_q <= state_q == ADDR && addr_hs ? '0 : state_q == DATA ? cnt_q + CNT_W'(1) : cnt_q;
      terr_q <= tmo;
    end
  end
`else
  assign tmo = 1'b0;
  assign timeout_err = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    gnt_d = gnt;
    last_d = last_q;
    case (state_q)
      IDLE: if (|req) begin
        state_d = ADDR;
        gnt_d = pick;
        last_d = pick;
      end
      ADDR: if (addr_hs) state_d = DATA;
      DATA: if (done || tmo) begin
        state_d = IDLE;
        gnt_d = '0;
      end
      default: begin
        state_d = IDLE;
        gnt_d = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt <= '0;
      last_q <= GNT_ARM1;
    end else begin
      state_q <= state_d;
      gnt <= gnt_d;
      last_q <= last_d;
    end
  end
endmodule
